// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external bus arbiter: state encoding, default
// bus widths and master indices.
package ext_bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ext_bus_arbiter_rr.sv
// Two-input round-robin picker; the master that did not win last time has
// priority when both request.
module rr_arbiter2
  import ext_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_any,
  output logic o_winner
);

  logic r_last_grant;

  assign o_any    = i_req0 | i_req1;
  assign o_winner = (i_req0 && i_req1) ? ~r_last_grant : i_req1;

  // After reset the debug port counts as last served, so the CPU wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= M_DBG;
    end else if (i_update && o_any) begin
      r_last_grant <= o_winner;
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Shares the multiplexed external bus between the CPU and the debug/loader
// port, running one SETUP/ACCESS/DONE transaction at a time.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  logic       w_any;
  logic       w_winner;
  logic       w_grant;

  assign w_grant = (r_state == IDLE) && w_any;
  assign busy    = (r_state != IDLE);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (m0_req),
    .i_req1   (m1_req),
    .i_update (w_grant),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Bus pins are loaded at grant so they are already stable during SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      grant_id     <= M_CPU;
      bus_addr     <= '0;
      bus_data_out <= '0;
      bus_data_oe  <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            grant_id     <= w_winner;
            r_we         <= w_winner ? m1_we    : m0_we;
            bus_addr     <= w_winner ? m1_addr  : m0_addr;
            bus_data_out <= w_winner ? m1_wdata : m0_wdata;
            bus_data_oe  <= w_winner ? m1_we    : m0_we;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= LP_CNT_LOAD;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              if (grant_id == M_DBG) m1_rdata <= bus_data_in;
              else                   m0_rdata <= bus_data_in;
            end
            // Release the data pins one cycle before the bus is handed on.
            bus_data_oe <= 1'b0;
            m0_ack      <= (grant_id == M_CPU);
            m1_ack      <= (grant_id == M_DBG);
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Testbench for ext_bus_arbiter: vector table plus multi-cycle sequences,
// with acks checked against a scoreboard queue.
module tb_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [3:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [11:0] bus_addr;
  logic [3:0]  bus_data_out, bus_data_in;
  logic        bus_data_oe, busy, grant_id;

  // Sweep instances (index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=15)
  logic        sw_req   [2];
  logic [3:0]  sw_din   [2];
  logic [3:0]  sw_rd0   [2];
  logic [3:0]  sw_rd1   [2];
  logic        sw_ack0  [2];
  logic        sw_ack1  [2];
  logic [11:0] sw_baddr [2];
  logic [3:0]  sw_bdout [2];
  logic        sw_oe    [2];
  logic        sw_busy  [2];
  logic        sw_gid   [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         m;
    logic [3:0] rd;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          m;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  din;
    logic [3:0]  exp_rd;
  } vec_t;
  vec_t vec [7];

  always #5 clk = ~clk;

  ext_bus_arbiter #(.ADDR_W(12), .DATA_W(4), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in), .busy(busy), .grant_id(grant_id)
  );

  ext_bus_arbiter #(.ADDR_W(12), .DATA_W(4), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .m0_req(sw_req[0]), .m0_we(1'b0), .m0_addr(12'h0AB), .m0_wdata(4'h0),
    .m0_rdata(sw_rd0[0]), .m0_ack(sw_ack0[0]),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(12'h000), .m1_wdata(4'h0),
    .m1_rdata(sw_rd1[0]), .m1_ack(sw_ack1[0]),
    .bus_addr(sw_baddr[0]), .bus_data_out(sw_bdout[0]), .bus_data_oe(sw_oe[0]),
    .bus_data_in(sw_din[0]), .busy(sw_busy[0]), .grant_id(sw_gid[0])
  );

  ext_bus_arbiter #(.ADDR_W(12), .DATA_W(4), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .m0_req(sw_req[1]), .m0_we(1'b0), .m0_addr(12'h0AB), .m0_wdata(4'h0),
    .m0_rdata(sw_rd0[1]), .m0_ack(sw_ack0[1]),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(12'h000), .m1_wdata(4'h0),
    .m1_rdata(sw_rd1[1]), .m1_ack(sw_ack1[1]),
    .bus_addr(sw_baddr[1]), .bus_data_out(sw_bdout[1]), .bus_data_oe(sw_oe[1]),
    .bus_data_in(sw_din[1]), .busy(sw_busy[1]), .grant_id(sw_gid[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int m, input logic v, input logic we,
                         input logic [11:0] a, input logic [3:0] wd);
    if (m == 0) begin
      m0_req = v; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = v; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m0_ack && m1_ack) chk("double_ack", 32'd1, 32'd0);
      else if (m0_ack || m1_ack) begin
        if (sb_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("sb_master", {31'b0, m1_ack}, e.m);
          chk("sb_rdata", m1_ack ? m1_rdata : m0_rdata, e.rd);
        end
      end
    end
  end

  // Cycle 0 is the IDLE cycle in which the request is first sampled.
  task automatic run_txn(input vec_t v);
    logic ack_m;
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin
        set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
        bus_data_in = v.din;
        sb_q.push_back('{v.m, v.exp_rd});
      end
      if (c == 2) set_req(v.m, 1'b1, ~v.we, ~v.addr, ~v.wdata);
      if (c == 5) set_req(v.m, 1'b0, 1'b0, 12'h000, 4'h0);
      @(negedge clk);
      ack_m = (v.m == 0) ? m0_ack : m1_ack;
      if (c >= 1 && c <= 4) begin
        chk("txn_addr", bus_addr, v.addr);
        chk("txn_grant_id", grant_id, v.m);
      end
      chk("txn_oe", bus_data_oe, (v.we && c >= 1 && c <= 3));
      if (v.we && c >= 1 && c <= 4) chk("txn_data_out", bus_data_out, v.wdata);
      chk("txn_busy", busy, (c >= 1 && c <= 4));
      chk("txn_ack", ack_m, (c == 4));
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ack_m   [4];
    int ack_cyc [4];
    bit got;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 12'h000, 4'h0);
    set_req(1, 1'b0, 1'b0, 12'h000, 4'h0);
    bus_data_in = 4'h0;
    sw_req[0] = 1'b0; sw_req[1] = 1'b0;
    sw_din[0] = 4'h0; sw_din[1] = 4'h0;

    vec[0] = '{0, 1'b0, 12'h3A5, 4'h0, 4'hC, 4'hC};
    vec[1] = '{1, 1'b1, 12'hFFF, 4'h7, 4'h5, 4'h0};
    vec[2] = '{1, 1'b0, 12'h000, 4'h0, 4'h9, 4'h9};
    vec[3] = '{0, 1'b1, 12'h123, 4'hA, 4'h3, 4'hC};
    vec[4] = '{1, 1'b1, 12'h800, 4'hF, 4'h2, 4'h9};
    vec[5] = '{0, 1'b0, 12'hFFF, 4'h0, 4'h0, 4'h0};
    vec[6] = '{1, 1'b0, 12'h555, 4'h0, 4'h6, 4'h6};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_ack0", m0_ack, 0);
    chk("rst_ack1", m1_ack, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_dout", bus_data_out, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    chk("rst_grant_id", grant_id, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) run_txn(vec[i]);
    chk("persist_rdata0", m0_rdata, 4'h0);
    chk("persist_rdata1", m1_rdata, 4'h6);

    // Contention: both request continuously
    set_req(0, 1'b1, 1'b0, 12'h100, 4'h0);
    set_req(1, 1'b1, 1'b0, 12'h200, 4'h0);
    bus_data_in = 4'hD;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{i % 2, 4'hD});
      ack_m[i] = -1; ack_cyc[i] = -1;
    end
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ack_m[n] = m1_ack; ack_cyc[n] = c;
        chk("cont_grant_id", grant_id, m1_ack);
        n++;
        if (n == 4) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
      end
      next_cycle();
    end
    chk("cont_ack_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order", ack_m[i], i % 2);
      chk("cont_ack_cycle", ack_cyc[i], 4 + 5 * i);
    end
    @(negedge clk);
    chk("cont_idle", busy, 0);
    next_cycle();

    // Request dropped mid-transaction; m0 arrives while m1 is busy
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        set_req(1, 1'b1, 1'b0, 12'h2C4, 4'h0);
        bus_data_in = 4'h8;
        sb_q.push_back('{1, 4'h8});
      end
      if (c == 2) begin
        set_req(1, 1'b0, 1'b0, 12'h000, 4'h0);
        set_req(0, 1'b1, 1'b0, 12'h0E1, 4'h0);
        sb_q.push_back('{0, 4'h4});
      end
      if (c == 4) bus_data_in = 4'h4;
      if (c == 10) m0_req = 1'b0;
      @(negedge clk);
      if (c == 3) chk("drop_addr_held", bus_addr, 12'h2C4);
      chk("drop_m1_ack", m1_ack, (c == 4));
      chk("drop_m0_ack", m0_ack, (c == 9));
      if (c == 5) chk("drop_idle", busy, 0);
      if (c == 6) begin
        chk("drop_next_gid", grant_id, 0);
        chk("drop_next_addr", bus_addr, 12'h0E1);
      end
      next_cycle();
    end

    // Reset during ACCESS of a write
    set_req(0, 1'b1, 1'b1, 12'h456, 4'h3);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_mid_oe_before", bus_data_oe, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_oe", bus_data_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", m0_ack, 0);
    set_req(0, 1'b0, 1'b0, 12'h000, 4'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    chk("rst_mid_rdata0", m0_rdata, 0);
    chk("rst_mid_rdata1", m1_rdata, 0);
    set_req(0, 1'b1, 1'b0, 12'h111, 4'h0);
    set_req(1, 1'b1, 1'b0, 12'h222, 4'h0);
    bus_data_in = 4'hE;
    sb_q.push_back('{0, 4'hE});
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (c == 1) chk("rst_first_gid", grant_id, 0);
      if (m0_ack || m1_ack) begin
        got = 1'b1;
        chk("rst_first_ack_m0", m0_ack, 1);
        m0_req = 1'b0; m1_req = 1'b0;
      end
      next_cycle();
    end
    chk("rst_first_ack_seen", got, 1);
    next_cycle();

    // WAIT_CYCLES sweep: sample point and latency
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 1 : 15;
      sw_req[k] = 1'b1;
      for (int c = 0; c <= w + 3; c++) begin
        sw_din[k] = (c == w + 1) ? 4'hA : ((c == w) ? 4'h3 : 4'h5);
        if (c == w + 3) sw_req[k] = 1'b0;
        @(negedge clk);
        chk("sweep_ack", sw_ack0[k], (c == w + 2));
        if (c == w + 2) chk("sweep_rdata", sw_rd0[k], 4'hA);
        next_cycle();
      end
    end

    chk("sb_empty", sb_q.size(), 0);
    chk("final_rdata0", m0_rdata, 4'hE);
    chk("final_rdata1", m1_rdata, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
